// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit paths.
//   rx_state_t : receiver FSM states
//   DATA_BITS  : data bits per frame (fixed at 8)
//   FRAME_BITS : bits per frame including start, parity (optional) and stop
//   IDLE_LEVEL : line level when no frame is in flight
// Build option: define UART_RX_PARITY_EN to include the even parity bit
// (11-bit frame); leave it undefined for a 10-bit frame without parity.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Free-running bit-period counter shared by the UART RX and TX engines.
// Ports:
//   clk     : system clock, rising edge
//   arst_n  : asynchronous reset, active low
//   restart : synchronous restart, count returns to 0 on the next edge
//   en      : count enable
//   mid     : count is at the half-bit point (CLKS_PER_BIT/2-1)
//   tick    : count is at the end of a bit period (CLKS_PER_BIT-1)
// The count wraps to 0 after tick, so consecutive ticks are one bit apart.
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic arst_n,
  input  logic restart,
  input  logic en,
  output logic mid,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == TICK_CNT) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
    end
  end

  assign mid  = en && (cnt == MID_CNT);
  assign tick = en && (cnt == TICK_CNT);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive engine: start(0), 8 data bits LSB first, optional even parity,
// stop(1). Each received byte is offered on a valid/ready handshake together
// with its parity and framing error flags.
// Ports:
//   clk          : system clock, rising edge
//   arst_n       : asynchronous reset, active low
//   rst          : synchronous clear, same effect as arst_n
//   en           : receiver enable; 0 drops any partial frame
//   serial_i     : asynchronous RX line, idle high
//   dat_o        : received byte, held until the next load
//   valid_o      : dat_o and error flags are valid
//   ready_i      : consumer accepts the byte when valid_o && ready_i
//   parity_err_o : parity mismatch for the byte on dat_o
//   frame_err_o  : stop bit sampled low for the byte on dat_o
//   overrun_o    : sticky, a frame completed while a byte was still pending
//   busy_o       : FSM is not in IDLE
// Build option: UART_RX_PARITY_EN enables the parity bit and its check;
// without it the frame is 10 bits and parity_err_o is tied to 0.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 serial_i,
  output logic [DATA_BITS-1:0] dat_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int BC_W = $clog2(DATA_BITS);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_BITS - 1);

  rx_state_t state, state_nxt;

  logic                 rx_meta, rx_s;
  logic                 mid, tick;
  logic                 timer_restart, timer_en;
  logic                 shift_en, stop_en;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 vld_p0;
  logic                 ferr_p0;
`ifdef UART_RX_PARITY_EN
  logic                 par_en;
  logic                 perr_p0;
  logic                 perr_q;
`endif

  // ---- input synchronizer -------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
    end else if (rst) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
    end else begin
      rx_meta <= serial_i;
      rx_s    <= rx_meta;
    end
  end

  // Timer restarts on every state entry so each state measures from its own
  // start; START -> DATA at mid therefore lands later ticks on bit centres.
  assign timer_en = en && (state != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .arst_n (arst_n),
    .restart(timer_restart),
    .en     (timer_en),
    .mid    (mid),
    .tick   (tick)
  );

  // ---- FSM state register -------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)  state <= IDLE;
    else if (rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- FSM next state and sample strobes ----------------------------------
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    stop_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) state_nxt = START;
        end
        START: begin
          if (mid) state_nxt = rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (tick) begin
            shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == LAST_BIT) state_nxt = PARITY;
`else
            if (bit_cnt == LAST_BIT) state_nxt = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_en    = 1'b1;
            state_nxt = STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            stop_en   = 1'b1;
            state_nxt = rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    timer_restart = rst || (state_nxt != state);
  end

  // ---- p0: bit assembly and stop sample -----------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      vld_p0  <= 1'b0;
      ferr_p0 <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_p0 <= 1'b0;
`endif
    end else if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      vld_p0  <= 1'b0;
      ferr_p0 <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_p0 <= 1'b0;
`endif
    end else begin
      vld_p0 <= stop_en;
      if (state == START) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BC_W'(1);
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: data ones plus the parity bit must be even.
      if (par_en) perr_p0 <= rx_s ^ (^shreg);
`endif
      if (stop_en) ferr_p0 <= ~rx_s;
    end
  end

  // ---- p1: output load and handshake --------------------------------------
  // A pending byte that is not taken in the load cycle wins; the new frame is
  // dropped and recorded only as an overrun.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dat_o       <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else if (rst) begin
      dat_o       <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q      <= 1'b0;
`endif
    end else begin
      if (vld_p0) begin
        if (!valid_o || ready_i) begin
          dat_o       <= shreg;
          frame_err_o <= ferr_p0;
`ifdef UART_RX_PARITY_EN
          perr_q      <= perr_p0;
`endif
          valid_o     <= 1'b1;
        end else begin
          overrun_o   <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int C = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n;
  logic       rst;
  logic       en;
  logic       serial_i;
  logic       ready_i;
  logic [7:0] dat_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  logic [10:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .rst         (rst),
    .en          (en),
    .serial_i    (serial_i),
    .dat_o       (dat_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // Log every accepted byte as {busy, parity_err, frame_err, data}.
  always @(negedge clk) begin
    if (valid_o) vcnt <= vcnt + 1;
    if (valid_o && ready_i) got_q.push_back({busy_o, parity_err_o, frame_err_o, dat_o});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int ones_of(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Parity bit that makes the total number of ones even.
  function automatic bit even_par(input logic [7:0] d);
    return (ones_of(d) % 2) == 1;
  endfunction

  // Expected accepted entry from what was put on the wire.
  function automatic logic [10:0] model(input logic [7:0] d, input bit par_bit, input bit stop);
    bit perr;
    bit ferr;
    bit bsy;
    perr = PAR_EN && (((ones_of(d) + int'(par_bit)) % 2) != 0);
    ferr = !stop;
    bsy  = !stop;
    return {bsy, perr, ferr, d};
  endfunction

  // Drive one frame; abort_idx >= 0 pulses arst_n in the middle of that bit.
  task automatic send(input logic [7:0] d, input bit par_bit, input bit stop,
                      input int abort_idx, input bit hold_low);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back(par_bit);
    bits.push_back(stop);
    for (int k = 0; k < bits.size(); k++) begin
      serial_i = bits[k];
      if (k == abort_idx) begin
        cyc(C / 2);
        chk("abort_busy_before", {31'd0, busy_o}, 32'd1);
        arst_n = 1'b0;
        cyc(2);
        chk("abort_busy_in_reset", {31'd0, busy_o}, 32'd0);
        chk("abort_valid_in_reset", {31'd0, valid_o}, 32'd0);
        arst_n   = 1'b1;
        serial_i = 1'b1;
        return;
      end
      cyc(C);
    end
    if (!hold_low) serial_i = 1'b1;
  endtask

  task automatic wait_got(input int budget);
    int n = 0;
    while (got_q.size() == 0 && n < budget) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic take(input string tag, input logic [10:0] exp);
    logic [31:0] obs;
    wait_got(6 * C);
    if (got_q.size() > 0) obs = {21'd0, got_q.pop_front()};
    else                  obs = 'x;
    chk(tag, obs, {21'd0, exp});
  endtask

  // One frame with ready_i=1: exactly one byte, valid for exactly one cycle.
  task automatic frame_test(input string tag, input logic [7:0] d, input bit par_bit, input bit stop);
    int v0;
    v0 = vcnt;
    send(d, par_bit, stop, -1, 1'b0);
    take({tag, "_entry"}, model(d, par_bit, stop));
    cyc(2 * C);
    chk({tag, "_vcycles"}, vcnt - v0, 32'd1);
    chk({tag, "_extra"}, got_q.size(), 32'd0);
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    bit pflip;
    bit stp;

    arst_n   = 1'b0;
    rst      = 1'b0;
    en       = 1'b1;
    serial_i = 1'b1;
    ready_i  = 1'b1;
    cyc(3);
    chk("reset_dat", {24'd0, dat_o}, 32'd0);
    chk("reset_flags", {27'd0, valid_o, parity_err_o, frame_err_o, overrun_o, busy_o}, 32'd0);
    arst_n = 1'b1;
    cyc(5);

    // Clean byte.
    frame_test("a5", 8'hA5, even_par(8'hA5), 1'b1);
    chk("a5_busy_after", {31'd0, busy_o}, 32'd0);

    // Corrupted parity bit.
    frame_test("3c", 8'h3C, !even_par(8'h3C), 1'b1);

    // Stop bit low followed by a long break.
    v0 = vcnt;
    send(8'h55, even_par(8'h55), 1'b0, -1, 1'b1);
    take("55_entry", model(8'h55, even_par(8'h55), 1'b0));
    cyc(20 * C);
    chk("break_busy", {31'd0, busy_o}, 32'd1);
    chk("break_no_second", got_q.size(), 32'd0);
    chk("break_vcycles", vcnt - v0, 32'd1);
    serial_i = 1'b1;
    cyc(C);
    chk("break_release_busy", {31'd0, busy_o}, 32'd0);

    // Overrun: two frames with the consumer stalled.
    ready_i = 1'b0;
    send(8'h11, even_par(8'h11), 1'b1, -1, 1'b0);
    cyc(2 * C);
    send(8'h22, even_par(8'h22), 1'b1, -1, 1'b0);
    cyc(2 * C);
    chk("ovr_dat", {24'd0, dat_o}, 32'h11);
    chk("ovr_valid", {31'd0, valid_o}, 32'd1);
    chk("ovr_flag", {31'd0, overrun_o}, 32'd1);
    chk("ovr_errs", {30'd0, parity_err_o, frame_err_o}, 32'd0);
    chk("ovr_none_taken", got_q.size(), 32'd0);
    ready_i = 1'b1;
    cyc(1);
    chk("ovr_valid_drop", {31'd0, valid_o}, 32'd0);
    take("ovr_entry", model(8'h11, even_par(8'h11), 1'b1));
    cyc(3 * C);
    chk("ovr_sticky", {31'd0, overrun_o}, 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
    chk("rst_dat", {24'd0, dat_o}, 32'd0);

    // Short glitch on an idle line.
    v0 = vcnt;
    serial_i = 1'b0;
    cyc(2);
    serial_i = 1'b1;
    cyc(1);
    chk("glitch_start", {31'd0, busy_o}, 32'd1);
    cyc(3 * C);
    chk("glitch_busy", {31'd0, busy_o}, 32'd0);
    chk("glitch_vcycles", vcnt - v0, 32'd0);

    // Receiver disabled: line activity ignored.
    v0 = vcnt;
    en = 1'b0;
    send(8'h77, even_par(8'h77), 1'b1, -1, 1'b0);
    cyc(2 * C);
    chk("dis_busy", {31'd0, busy_o}, 32'd0);
    chk("dis_vcycles", vcnt - v0, 32'd0);
    en = 1'b1;
    cyc(2 * C);

    // Reset during data bit 4, then a clean frame.
    v0 = vcnt;
    send(8'hF0, even_par(8'hF0), 1'b1, 5, 1'b0);
    cyc(3 * C);
    chk("abort_vcycles", vcnt - v0, 32'd0);
    chk("abort_busy_after", {31'd0, busy_o}, 32'd0);
    frame_test("0f", 8'h0F, even_par(8'h0F), 1'b1);

    // Random frames.
    for (int n = 0; n < 8; n++) begin
      d     = 8'($urandom_range(0, 255));
      pflip = ($urandom_range(0, 3) == 0);
      stp   = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(1, 3) * C);
      frame_test($sformatf("rnd%0d", n), d, even_par(d) ^ pflip, stp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
